// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker
// ----------------
// Read-side consumer for the asynchronous FIFO. It runs entirely in the FIFO
// read clock domain. It pops DATA_WIDTH-bit entries, packs NIBBLES of them
// LSB-first into one OUT_WIDTH-bit word, and offers that word downstream on a
// valid/ready handshake. It also counts the words it has delivered.
//
// Ports
//   Rd_clk      in   1           FIFO read clock; every flop uses its rising edge
//   reset       in   1           asynchronous active-low reset
//   Rd_Empty    in   1           FIFO empty flag (registered in Rd_clk domain)
//   Fifo_data   in   DATA_WIDTH  FIFO read data, valid the cycle after a pop
//   Rd_en       out  1           pop request (combinational)
//   Enable      in   1           permits new pops
//   Word_out    out  OUT_WIDTH   assembled word (registered)
//   Word_valid  out  1           Word_out holds a complete word (registered)
//   Word_ready  in   1           downstream accepts Word_out
//   Word_count  out  8           words delivered since reset, wraps 255 -> 0
//
// Also contains fifo_rd_unpacker_chk, the invariant checker bound inside the top.

module fifo_rd_unpacker_chk #(
  parameter int NIBBLES = 4,
  parameter int CW      = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rd_en,
  input logic          rd_empty,
  input logic          in_fill,
  input logic [CW-1:0] issued,
  input logic [CW-1:0] captured
);

  localparam logic [CW-1:0] FULL = CW'(NIBBLES);

  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    rd_en |-> !rd_empty);

  a_pop_only_in_fill : assert property (@(posedge clk) disable iff (!rst_n)
    rd_en |-> in_fill);

  a_counter_order : assert property (@(posedge clk) disable iff (!rst_n)
    (captured <= issued) && (issued <= FULL));

endmodule

module fifo_rd_unpacker #(
  parameter int DATA_WIDTH = 4,
  parameter int NIBBLES    = 4
) (
  input  logic                          Rd_clk,
  input  logic                          reset,
  input  logic                          Rd_Empty,
  input  logic [DATA_WIDTH-1:0]         Fifo_data,
  output logic                          Rd_en,
  input  logic                          Enable,
  output logic [DATA_WIDTH*NIBBLES-1:0] Word_out,
  output logic                          Word_valid,
  input  logic                          Word_ready,
  output logic [7:0]                    Word_count
);

  localparam int OUT_WIDTH = DATA_WIDTH * NIBBLES;
  // Counters must be able to hold the value NIBBLES itself, not just NIBBLES-1.
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] FULL = CW'(NIBBLES);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               state_q,      state_d;
  logic [CW-1:0]        issued_q,     issued_d;
  logic [CW-1:0]        captured_q,   captured_d;
  logic                 rd_pending_q, rd_pending_d;
  logic [OUT_WIDTH-1:0] word_q,       word_d;
  logic                 valid_q,      valid_d;
  logic [7:0]           count_q,      count_d;
  logic                 rd_en_s;

  // Next-state, counter, capture and pop-request logic.
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    captured_d   = captured_q;
    rd_pending_d = 1'b0;
    word_d       = word_q;
    valid_d      = 1'b0;
    count_d      = count_q;
    rd_en_s      = 1'b0;

    // A pop from last cycle lands now. This is independent of Enable, so a
    // capture already in flight always completes. Earlier slots stay as
    // they are.
    if (rd_pending_q && (captured_q < FULL)) begin
      for (int k = 0; k < NIBBLES; k++) begin
        word_d[k*DATA_WIDTH +: DATA_WIDTH] = (captured_q == CW'(k)) ?
                                             Fifo_data :
                                             word_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
      captured_d = captured_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      captured_d = captured_q;
    end

    case (state_q)
      ST_FILL: begin
        // reset is included so that no pop can leave while reset is held.
        rd_en_s      = reset & Enable & ~Rd_Empty & (issued_q < FULL);
        issued_d     = issued_q + CW'(rd_en_s);
        rd_pending_d = rd_en_s;
        if (issued_d == FULL) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FILL;
        end
      end

      ST_DRAIN: begin
        // Every pop has been issued. Wait here until the last entry lands.
        if (captured_d == FULL) begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (Word_ready) begin
          state_d      = ST_FILL;
          issued_d     = '0;
          captured_d   = '0;
          rd_pending_d = 1'b0;
          count_d      = count_q + 8'd1;
          valid_d      = 1'b0;
        end else begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d      = ST_FILL;
        issued_d     = '0;
        captured_d   = '0;
        rd_pending_d = 1'b0;
        valid_d      = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with asynchronous active-low clear.
  always_ff @(posedge Rd_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FILL;
      issued_q     <= '0;
      captured_q   <= '0;
      rd_pending_q <= 1'b0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      captured_q   <= captured_d;
      rd_pending_q <= rd_pending_d;
      word_q       <= word_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
    end
  end

  assign Rd_en      = rd_en_s;
  assign Word_out   = word_q;
  assign Word_valid = valid_q;
  assign Word_count = count_q;

  fifo_rd_unpacker_chk #(
    .NIBBLES (NIBBLES),
    .CW      (CW)
  ) u_chk (
    .clk      (Rd_clk),
    .rst_n    (reset),
    .rd_en    (rd_en_s),
    .rd_empty (Rd_Empty),
    .in_fill  (state_q == ST_FILL),
    .issued   (issued_q),
    .captured (captured_q)
  );

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Self-checking bench for fifo_rd_unpacker (DATA_WIDTH=4, NIBBLES=4).
// It contains a simple FIFO model with a registered pop: it pops on an edge
// where Rd_en is high, and data appears after that edge. The reference model
// treats the FIFO contents as one ordered nibble stream. Every handshake
// must deliver the next four nibbles of that stream, LSB first. The word
// counter is modelled as an 8-bit wrapping count of handshakes.
module tb_fifo_rd_unpacker;
  localparam int DW  = 4;
  localparam int NIB = 4;
  localparam int OW  = DW * NIB;

  logic          clk;
  logic          rst_n;
  logic          rd_empty;
  logic [DW-1:0] fifo_data;
  logic          rd_en;
  logic          enable;
  logic [OW-1:0] word_out;
  logic          word_valid;
  logic          word_ready;
  logic [7:0]    word_count;

  // FIFO storage and pointers.
  logic [DW-1:0] mem [0:4095];
  logic [11:0]   rp = 12'd0;
  logic [11:0]   wp = 12'd0;

  // Reference model state.
  logic [DW-1:0] exp_q [$];
  logic [7:0]    exp_count;
  int            delivered;
  int            n_total;
  int            n_pass;

  fifo_rd_unpacker #(.DATA_WIDTH(DW), .NIBBLES(NIB)) dut (
    .Rd_clk     (clk),
    .reset      (rst_n),
    .Rd_Empty   (rd_empty),
    .Fifo_data  (fifo_data),
    .Rd_en      (rd_en),
    .Enable     (enable),
    .Word_out   (word_out),
    .Word_valid (word_valid),
    .Word_ready (word_ready),
    .Word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rd_empty = (rp == wp);

  // FIFO read port: a pop sampled on an edge presents its data after that edge.
  always @(posedge clk) begin
    if (rd_en) begin
      fifo_data <= mem[rp];
      rp        <= rp + 12'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wp] = v;
    wp = wp + 12'd1;
    exp_q.push_back(v);
  endtask

  // After a reset, the model stream restarts from whatever is still in the
  // FIFO. Entries already popped are lost.
  task automatic resync_model();
    exp_q.delete();
    for (int i = 0; i < int'(wp - rp); i++) exp_q.push_back(mem[rp + 12'(i)]);
  endtask

  // Run one clock cycle. This checks a handshake against the model, checks
  // the no-pop-when-empty rule, and checks the word counter afterwards.
  task automatic step();
    logic          hs;
    logic [OW-1:0] e;
    #1;
    hs = word_valid & word_ready;
    if (hs) begin
      if (exp_q.size() >= NIB) begin
        e = '0;
        for (int k = 0; k < NIB; k++) e[k*DW +: DW] = exp_q.pop_front();
        check("word_out", 32'(word_out), 32'(e));
      end else begin
        check("spurious_word", 32'(exp_q.size()), 32'(NIB));
      end
    end
    if (rd_en) check("rd_en_while_empty", 32'(rd_empty), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      exp_count = exp_count + 8'd1;
      delivered++;
    end
    check("word_count", 32'(word_count), 32'(exp_count));
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (word_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},      32'(rd_en),      32'd0);
    check({tag, "_word_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_word_out"},   32'(word_out),   32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int rd_w0;
    int rd_w1;
    int pushed;
    int n_need;
    n_total    = 0;
    n_pass     = 0;
    delivered  = 0;
    exp_count  = 8'd0;
    rst_n      = 1'b1;
    enable     = 1'b0;
    word_ready = 1'b0;
    #2;

    // Reset with the FIFO preloaded with 1..8.
    rst_n = 1'b0;
    for (int v = 1; v <= 8; v++) push(4'(v));
    enable     = 1'b1;
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_reset_outputs("reset");
      step();
    end
    resync_model();
    rst_n = 1'b1;

    // Back-to-back words: the valid pulse lands in cycles 5 and 11 after release.
    rd_w0 = 0;
    rd_w1 = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c == 0) check("first_rd_en", 32'(rd_en), 32'd1);
      check("b2b_valid_timing", 32'(word_valid), 32'((c == 5) || (c == 11)));
      if (rd_en && (c < 6)) rd_w0++;
      if (rd_en && (c >= 6)) rd_w1++;
      step();
    end
    check("b2b_pops_word0", 32'(rd_w0), 32'd4);
    check("b2b_pops_word1", 32'(rd_w1), 32'd4);
    check("b2b_count", 32'(word_count), 32'd2);

    // Empty stall: only two entries for ten cycles, then the other two.
    push(4'hA);
    push(4'hB);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_valid", 32'(word_valid), 32'd0);
      step();
    end
    push(4'hC);
    push(4'hD);
    wait_valid("stall_timeout", 20);
    check("stall_word", 32'(word_out), 32'h0000DCBA);
    step();

    // Backpressure: hold the word for 7 cycles while more data waits in the FIFO.
    word_ready = 1'b0;
    for (int v = 1; v <= 8; v++) push(4'(v));
    wait_valid("bp_timeout", 20);
    for (int i = 0; i < 7; i++) begin
      check("bp_valid", 32'(word_valid), 32'd1);
      check("bp_word", 32'(word_out), 32'h00004321);
      check("bp_rd_en", 32'(rd_en), 32'd0);
      step();
    end
    word_ready = 1'b1;
    step();
    check("bp_count", 32'(word_count), 32'd4);
    wait_valid("bp2_timeout", 20);
    step();

    // Enable gating after two pops (9, A).
    push(4'h9);
    push(4'hA);
    push(4'hB);
    push(4'hC);
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gate_rd_en", 32'(rd_en), 32'd0);
      step();
    end
    check("gate_partial", 32'(word_out[7:0]), 32'h000000A9);
    enable = 1'b1;
    wait_valid("gate_timeout", 20);
    check("gate_word", 32'(word_out), 32'h0000CBA9);
    step();

    // Randomized traffic up to 256 words in total, so the counter wraps to 0.
    n_need = (256 - delivered) * NIB;
    pushed = 0;
    for (int cyc = 0; (cyc < 30000) && (delivered < 256); cyc++) begin
      enable     = ($urandom_range(0, 3) != 0);
      word_ready = ($urandom_range(0, 1) == 1);
      if ((pushed < n_need) && ($urandom_range(0, 1) == 1)) begin
        push(4'($urandom_range(0, 15)));
        pushed++;
      end
      step();
    end
    check("wrap_delivered", 32'(delivered), 32'd256);
    check("wrap_count", 32'(word_count), 32'd0);
    enable     = 1'b1;
    word_ready = 1'b1;

    // Reset after two captures. The next word uses fresh entries only.
    push(4'h3);
    push(4'h5);
    for (int i = 0; i < 4; i++) step();
    rst_n     = 1'b0;
    exp_count = 8'd0;
    resync_model();
    for (int i = 0; i < 2; i++) begin
      #1;
      check_reset_outputs("midreset");
      step();
    end
    rst_n = 1'b1;
    push(4'h6);
    push(4'h7);
    push(4'h8);
    push(4'h9);
    wait_valid("fresh_timeout", 20);
    check("fresh_word", 32'(word_out), 32'h00009876);
    step();
    check("fresh_count", 32'(word_count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
